rc4_prga: RTL and testbench
===========================

RC4_PRGA -- requirements
Module: rc4_prga

Interface
REQ-001 Parameter MSG_LEN, 32, number of ciphertext bytes decrypted per run (1..256).
REQ-002 Parameter CHECK_ASCII, 1, enables early abort when a plaintext byte is not in {0x20, 0x61..0x7A}.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse; begins a run when idle.
REQ-006 s_addr  out  8  S-RAM address.
REQ-007 s_rdata  in  8  S-RAM read data, valid the cycle after s_addr is presented.
REQ-008 s_wdata  out  8  S-RAM write data.
REQ-009 s_wr_en  out  1  S-RAM write enable.
REQ-010 ct_addr  out  8  ciphertext-ROM address; 1-cycle read latency.
REQ-011 ct_rdata  in  8  ciphertext byte.
REQ-012 pt_addr  out  8  plaintext-RAM address.
REQ-013 pt_wdata  out  8  plaintext byte.
REQ-014 pt_wr_en  out  1  plaintext-RAM write enable.
REQ-015 task_on  out  1  high while a run is in progress, for S-RAM port arbitration.
REQ-016 fin_strobe  out  1  one-cycle pulse at end of run.
REQ-017 key_bad  out  1  result flag: run aborted on an invalid byte; held until the next accepted start.

Function
REQ-018 Algorithm: i=j=0; for k=0..MSG_LEN-1: i=i+1; j=j+S[i]; swap S[i],S[j]; pt[k]=ct[k] XOR S[(S[i]+S[j]) mod 256]; all index arithmetic 8-bit wrap-around.
REQ-019 States: IDLE, RD_I, LT_I, RD_J, LT_J, WR_I, WR_J, RD_F, LT_F, WR_PT, DONE.
REQ-020 IDLE: on start, clear i, j, k and key_bad, go to RD_I; otherwise stay.
REQ-021 RD_I: s_addr=i+1, register i<=i+1.
REQ-022 LT_I: si<=s_rdata, j<=j+s_rdata.
REQ-023 RD_J: s_addr=j.
REQ-024 LT_J: sj<=s_rdata.
REQ-025 WR_I: s_addr=i, s_wdata=sj, s_wr_en=1.
REQ-026 WR_J: s_addr=j, s_wdata=si, s_wr_en=1.
REQ-027 RD_F: s_addr=si+sj.
REQ-028 LT_F: f<=s_rdata.
REQ-029 WR_PT: pt_addr=k, pt_wdata=f XOR ct_rdata, pt_wr_en=1; ct_addr=k in every state, so ct_rdata is stable here.
REQ-030 WR_PT exit: if CHECK_ASCII and byte invalid, set key_bad and go to DONE; else if k==MSG_LEN-1 go to DONE; else k<=k+1 and go to RD_I.
REQ-031 Each byte takes exactly 9 cycles; a full valid run takes 9*MSG_LEN cycles from the cycle after start to DONE.
REQ-032 The invalid byte is still written before abort.
REQ-033 DONE: fin_strobe=1 for one cycle, return to IDLE.
REQ-034 task_on is high in every state except IDLE.
REQ-035 start is ignored outside IDLE.
REQ-036 i==j: two writes of the same value; S remains a permutation.
REQ-037 s_wr_en and pt_wr_en are 0 in all states not listed above.

Reset
REQ-038 rst low at a clock edge forces IDLE and clears i, j, k, si, sj, f and key_bad, including mid-run.
REQ-039 During and after reset, all outputs are 0; no memory write is issued.

Structure
REQ-040 Package rc4_pkg holds the state enum, the ASCII bounds (0x20, 0x61, 0x7A) and the MSG_LEN default.
REQ-041 Split into the FSM (top rc4_prga) and one sub-module, prga_datapath, which holds i, j, k, si, sj, f and the address/data muxes.

Verification
REQ-042 S=identity, ct={0x63,0x25}, MSG_LEN=2 -> pt={0x61,0x20}; S[2]=3, S[3]=2; fin_strobe at cycle 19 after start; key_bad=0.
REQ-043 S=identity, ct[0]=0x00, CHECK_ASCII=1 -> pt[0]=0x02 written; key_bad=1; fin_strobe after 9 cycles; no second pt write.
REQ-044 Same as REQ-043 with CHECK_ASCII=0 and MSG_LEN=2 -> both bytes written; key_bad=0.
REQ-045 rst low at cycle 5 of a run -> next cycle: IDLE, task_on=0, all outputs 0; new start re-runs from i=j=0.
REQ-046 start pulsed mid-run -> ignored; cycle count unchanged.
REQ-047 MSG_LEN=256 random key-scheduled S -> pt matches a golden model; k wraps 255 without overflow; S is still a permutation.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream decryptor (rc4_prga).
// Holds the FSM state encoding, the plaintext character-class bounds used
// for the early-abort check, the default message length, and a helper that
// classifies one plaintext byte.
package rc4_pkg;

  localparam int MSG_LEN_DEFAULT = 32;

  // Accepted plaintext characters: space, or lower-case 'a'..'z'.
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LO    = 8'h61;
  localparam logic [7:0] ASCII_HI    = 8'h7A;

  // FSM state encoding, kept as plain constants for legacy tools.
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_RD_I  = 4'd1;
  localparam logic [3:0] ST_LT_I  = 4'd2;
  localparam logic [3:0] ST_RD_J  = 4'd3;
  localparam logic [3:0] ST_LT_J  = 4'd4;
  localparam logic [3:0] ST_WR_I  = 4'd5;
  localparam logic [3:0] ST_WR_J  = 4'd6;
  localparam logic [3:0] ST_RD_F  = 4'd7;
  localparam logic [3:0] ST_LT_F  = 4'd8;
  localparam logic [3:0] ST_WR_PT = 4'd9;
  localparam logic [3:0] ST_DONE  = 4'd10;

  function automatic logic is_valid_byte(input logic [7:0] b);
    return (b == ASCII_SPACE) || ((b >= ASCII_LO) && (b <= ASCII_HI));
  endfunction

endpackage

// File: rtl/rc4_prga_datapath.sv
// Datapath for rc4_prga: index registers i, j, k, the latched S values
// si, sj, f, and the S-RAM / ciphertext / plaintext address and data muxes.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   state             current FSM state from the controller
//   clear             start accepted in IDLE: zero i, j, k
//   k_inc             advance to the next message byte
//   s_rdata, ct_rdata memory read data (1-cycle latency)
//   s_addr/s_wdata/s_wr_en, ct_addr, pt_addr/pt_wdata/pt_wr_en  memory ports
//   k                 current byte index
//   byte_valid        current plaintext byte is in the accepted set
module prga_datapath
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic       clear,
  input  logic       k_inc,
  input  logic [7:0] s_rdata,
  input  logic [7:0] ct_rdata,
  output logic [7:0] s_addr,
  output logic [7:0] s_wdata,
  output logic       s_wr_en,
  output logic [7:0] ct_addr,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wdata,
  output logic       pt_wr_en,
  output logic [7:0] k,
  output logic       byte_valid
);

  logic [7:0] i, j, si, sj, f;
  logic [7:0] pt_byte;

  assign pt_byte    = f ^ ct_rdata;
  assign byte_valid = is_valid_byte(pt_byte);

  // Outputs are forced to zero while reset is asserted so that no memory
  // write can escape in the cycle reset is first applied.
  assign ct_addr = rst ? k : 8'h00;

  // Register updates: each latch state captures the S-RAM word requested
  // in the preceding read state. i is bumped in RD_I so later states
  // address the new i directly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      i  <= 8'h00;
      j  <= 8'h00;
      k  <= 8'h00;
      si <= 8'h00;
      sj <= 8'h00;
      f  <= 8'h00;
    end else begin
      if (clear) begin
        i <= 8'h00;
        j <= 8'h00;
        k <= 8'h00;
      end
      case (state)
        ST_RD_I: i <= i + 8'd1;
        ST_LT_I: begin
          si <= s_rdata;
          j  <= j + s_rdata;
        end
        ST_LT_J: sj <= s_rdata;
        ST_LT_F: f  <= s_rdata;
        default: ;
      endcase
      if (k_inc) k <= k + 8'd1;
    end
  end

  // Memory port muxes. When i == j the two write states store the same
  // value to the same address, so S stays a permutation.
  always_comb begin
    s_addr   = 8'h00;
    s_wdata  = 8'h00;
    s_wr_en  = 1'b0;
    pt_addr  = 8'h00;
    pt_wdata = 8'h00;
    pt_wr_en = 1'b0;
    if (rst) begin
      case (state)
        ST_RD_I: s_addr = i + 8'd1;
        ST_RD_J: s_addr = j;
        ST_WR_I: begin
          s_addr  = i;
          s_wdata = sj;
          s_wr_en = 1'b1;
        end
        ST_WR_J: begin
          s_addr  = j;
          s_wdata = si;
          s_wr_en = 1'b1;
        end
        ST_RD_F: s_addr = si + sj;
        ST_WR_PT: begin
          pt_addr  = k;
          pt_wdata = pt_byte;
          pt_wr_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rc4_prga.sv
// RC4 pseudo-random generation and decryption controller. Walks an
// already key-scheduled S-RAM, producing one keystream byte every 9 cycles,
// XORs it with the ciphertext ROM and writes the plaintext RAM. Optionally
// aborts as soon as a decrypted byte is outside {space, 'a'..'z'}.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   start                    one-cycle pulse, accepted only in IDLE
//   s_addr/s_rdata/s_wdata/s_wr_en  S-RAM port
//   ct_addr/ct_rdata         ciphertext ROM port
//   pt_addr/pt_wdata/pt_wr_en       plaintext RAM port
//   task_on                  run in progress (S-RAM arbitration)
//   fin_strobe               one-cycle pulse at end of run
//   key_bad                  last run aborted on an invalid byte
module rc4_prga
  import rc4_pkg::*;
#(
  parameter int MSG_LEN     = MSG_LEN_DEFAULT,
  parameter int CHECK_ASCII = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rdata,
  output logic [7:0] s_wdata,
  output logic       s_wr_en,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rdata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wdata,
  output logic       pt_wr_en,
  output logic       task_on,
  output logic       fin_strobe,
  output logic       key_bad
);

  localparam logic [7:0] K_LAST   = 8'(MSG_LEN - 1);
  localparam logic       CHECK_EN = (CHECK_ASCII != 0);

  logic [3:0] state, state_next;
  logic       clear, k_inc, byte_valid, byte_bad, k_last;
  logic [7:0] k;

  assign clear      = (state == ST_IDLE) && start;
  assign byte_bad   = CHECK_EN && !byte_valid;
  assign k_last     = (k == K_LAST);
  assign k_inc      = (state == ST_WR_PT) && !byte_bad && !k_last;
  assign task_on    = rst && (state != ST_IDLE);
  assign fin_strobe = rst && (state == ST_DONE);

  prga_datapath u_datapath (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .clear      (clear),
    .k_inc      (k_inc),
    .s_rdata    (s_rdata),
    .ct_rdata   (ct_rdata),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wr_en    (s_wr_en),
    .ct_addr    (ct_addr),
    .pt_addr    (pt_addr),
    .pt_wdata   (pt_wdata),
    .pt_wr_en   (pt_wr_en),
    .k          (k),
    .byte_valid (byte_valid)
  );

  // Linear 9-state loop per byte; WR_PT decides between next byte, normal
  // completion and abort (the offending byte has already been written).
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_RD_I;
      ST_RD_I:  state_next = ST_LT_I;
      ST_LT_I:  state_next = ST_RD_J;
      ST_RD_J:  state_next = ST_LT_J;
      ST_LT_J:  state_next = ST_WR_I;
      ST_WR_I:  state_next = ST_WR_J;
      ST_WR_J:  state_next = ST_RD_F;
      ST_RD_F:  state_next = ST_LT_F;
      ST_LT_F:  state_next = ST_WR_PT;
      ST_WR_PT: state_next = (byte_bad || k_last) ? ST_DONE : ST_RD_I;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // key_bad is a sticky result flag, cleared only when a new run starts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      key_bad <= 1'b0;
    end else begin
      state <= state_next;
      if (clear)
        key_bad <= 1'b0;
      else if ((state == ST_WR_PT) && byte_bad)
        key_bad <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rc4_prga.sv
// Self-checking bench for rc4_prga. Three instances share one S-RAM,
// ciphertext ROM and plaintext RAM model; 'sel' chooses which instance
// owns the memories. Instance a: MSG_LEN=2 with ASCII check, b: MSG_LEN=2
// without check, c: MSG_LEN=256 without check.
module tb_rc4_prga;

  logic clk, rst;
  logic start_a, start_b, start_c;
  logic [7:0] s_rdata_q, ct_rdata_q;
  int sel;
  int checks, errors;

  logic [7:0] a_s_addr, a_s_wdata, a_ct_addr, a_pt_addr, a_pt_wdata;
  logic a_s_wr_en, a_pt_wr_en, a_task_on, a_fin, a_key_bad;
  logic [7:0] b_s_addr, b_s_wdata, b_ct_addr, b_pt_addr, b_pt_wdata;
  logic b_s_wr_en, b_pt_wr_en, b_task_on, b_fin, b_key_bad;
  logic [7:0] c_s_addr, c_s_wdata, c_ct_addr, c_pt_addr, c_pt_wdata;
  logic c_s_wr_en, c_pt_wr_en, c_task_on, c_fin, c_key_bad;

  logic [44:0] out_a, out_b, out_c, m_out;
  logic [7:0] m_s_addr, m_s_wdata, m_ct_addr, m_pt_addr, m_pt_wdata;
  logic m_s_wr_en, m_pt_wr_en, m_task_on, m_fin, m_key_bad;

  logic [7:0] s_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  int pt_wr_count;

  logic       ld_en;
  logic [7:0] ld_addr, ld_s, ld_ct;

  logic [7:0] s_init [256];
  logic [7:0] ct_init [256];
  logic [7:0] pt_exp [256];
  logic [7:0] ms [256];

  rc4_prga #(.MSG_LEN(2), .CHECK_ASCII(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .s_addr(a_s_addr), .s_rdata(s_rdata_q), .s_wdata(a_s_wdata), .s_wr_en(a_s_wr_en),
    .ct_addr(a_ct_addr), .ct_rdata(ct_rdata_q),
    .pt_addr(a_pt_addr), .pt_wdata(a_pt_wdata), .pt_wr_en(a_pt_wr_en),
    .task_on(a_task_on), .fin_strobe(a_fin), .key_bad(a_key_bad)
  );

  rc4_prga #(.MSG_LEN(2), .CHECK_ASCII(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .s_addr(b_s_addr), .s_rdata(s_rdata_q), .s_wdata(b_s_wdata), .s_wr_en(b_s_wr_en),
    .ct_addr(b_ct_addr), .ct_rdata(ct_rdata_q),
    .pt_addr(b_pt_addr), .pt_wdata(b_pt_wdata), .pt_wr_en(b_pt_wr_en),
    .task_on(b_task_on), .fin_strobe(b_fin), .key_bad(b_key_bad)
  );

  rc4_prga #(.MSG_LEN(256), .CHECK_ASCII(0)) dut_c (
    .clk(clk), .rst(rst), .start(start_c),
    .s_addr(c_s_addr), .s_rdata(s_rdata_q), .s_wdata(c_s_wdata), .s_wr_en(c_s_wr_en),
    .ct_addr(c_ct_addr), .ct_rdata(ct_rdata_q),
    .pt_addr(c_pt_addr), .pt_wdata(c_pt_wdata), .pt_wr_en(c_pt_wr_en),
    .task_on(c_task_on), .fin_strobe(c_fin), .key_bad(c_key_bad)
  );

  assign out_a = {a_s_addr, a_s_wdata, a_s_wr_en, a_ct_addr, a_pt_addr, a_pt_wdata,
                  a_pt_wr_en, a_task_on, a_fin, a_key_bad};
  assign out_b = {b_s_addr, b_s_wdata, b_s_wr_en, b_ct_addr, b_pt_addr, b_pt_wdata,
                  b_pt_wr_en, b_task_on, b_fin, b_key_bad};
  assign out_c = {c_s_addr, c_s_wdata, c_s_wr_en, c_ct_addr, c_pt_addr, c_pt_wdata,
                  c_pt_wr_en, c_task_on, c_fin, c_key_bad};

  always_comb begin
    case (sel)
      1:       m_out = out_b;
      2:       m_out = out_c;
      default: m_out = out_a;
    endcase
  end

  assign m_s_addr   = m_out[44:37];
  assign m_s_wdata  = m_out[36:29];
  assign m_s_wr_en  = m_out[28];
  assign m_ct_addr  = m_out[27:20];
  assign m_pt_addr  = m_out[19:12];
  assign m_pt_wdata = m_out[11:4];
  assign m_pt_wr_en = m_out[3];
  assign m_task_on  = m_out[2];
  assign m_fin      = m_out[1];
  assign m_key_bad  = m_out[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: registered reads (1-cycle latency), bench loading has
  // priority over DUT writes.
  always @(posedge clk) begin
    s_rdata_q  <= s_mem[m_s_addr];
    ct_rdata_q <= ct_mem[m_ct_addr];
    if (ld_en) begin
      s_mem[ld_addr]  <= ld_s;
      ct_mem[ld_addr] <= ld_ct;
      pt_mem[ld_addr] <= 8'h00;
    end else begin
      if (m_s_wr_en) s_mem[m_s_addr] <= m_s_wdata;
      if (m_pt_wr_en) begin
        pt_mem[m_pt_addr] <= m_pt_wdata;
        pt_wr_count <= pt_wr_count + 1;
      end
    end
  end

  task automatic set_start(input int which, input logic v);
    case (which)
      1:       start_b = v;
      2:       start_c = v;
      default: start_a = v;
    endcase
  endtask

  task automatic load_mems();
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 8'(a);
      ld_s    = s_init[a];
      ld_ct   = ct_init[a];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic set_identity(input logic [7:0] ct0, input logic [7:0] ct1);
    for (int a = 0; a < 256; a++) begin
      s_init[a]  = 8'(a);
      ct_init[a] = 8'h00;
    end
    ct_init[0] = ct0;
    ct_init[1] = ct1;
  endtask

  // Starts a run on one instance and counts cycles until fin_strobe,
  // cycle 1 being the first cycle after start is sampled.
  task automatic run_sel(input int which, input int limit, input int pulse_at,
                         output int cycles);
    bit finished;
    finished = 1'b0;
    cycles   = 0;
    sel      = which;
    @(negedge clk);
    set_start(which, 1'b1);
    while (!finished && cycles < limit) begin
      @(negedge clk);
      cycles++;
      set_start(which, cycles == pulse_at);
      if (m_fin) finished = 1'b1;
    end
    set_start(which, 1'b0);
    checks++;
    if (!finished) begin
      errors++;
      $display("[TB] FAIL run_timeout: got no fin_strobe, required one within %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    ld_en = 1'b0; ld_addr = 8'h00; ld_s = 8'h00; ld_ct = 8'h00;
    sel = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_a !== 45'd0) begin errors++; $display("[TB] FAIL reset_out_a: got %h, required 0", out_a); end
    checks++;
    if (out_b !== 45'd0) begin errors++; $display("[TB] FAIL reset_out_b: got %h, required 0", out_b); end
    checks++;
    if (out_c !== 45'd0) begin errors++; $display("[TB] FAIL reset_out_c: got %h, required 0", out_c); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_a, out_b, out_c} !== 135'd0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got %h %h %h, required all 0", out_a, out_b, out_c);
    end
  endtask

  task automatic test_invalid_abort();
    int cyc, wr0;
    set_identity(8'h00, 8'h25);
    load_mems();
    wr0 = pt_wr_count;
    run_sel(0, 50, -1, cyc);
    checks++;
    if (cyc !== 10) begin errors++; $display("[TB] FAIL abort_cycles: got %0d, required 10", cyc); end
    checks++;
    if (pt_mem[0] !== 8'h02) begin errors++; $display("[TB] FAIL abort_pt0: got %h, required 02", pt_mem[0]); end
    checks++;
    if (pt_wr_count - wr0 !== 1) begin errors++; $display("[TB] FAIL abort_writes: got %0d, required 1", pt_wr_count - wr0); end
    checks++;
    if (m_key_bad !== 1'b1) begin errors++; $display("[TB] FAIL abort_key_bad: got %b, required 1", m_key_bad); end
  endtask

  task automatic test_key_bad_hold();
    repeat (5) @(negedge clk);
    checks++;
    if (a_key_bad !== 1'b1 || a_task_on !== 1'b0) begin
      errors++;
      $display("[TB] FAIL key_bad_hold: got key_bad=%b task_on=%b, required 1 0", a_key_bad, a_task_on);
    end
  endtask

  task automatic check_basic_result(input string tag, input int cyc);
    checks++;
    if (cyc !== 19) begin errors++; $display("[TB] FAIL %s_cycles: got %0d, required 19", tag, cyc); end
    checks++;
    if (pt_mem[0] !== 8'h61 || pt_mem[1] !== 8'h20) begin
      errors++;
      $display("[TB] FAIL %s_pt: got %h %h, required 61 20", tag, pt_mem[0], pt_mem[1]);
    end
    checks++;
    if (s_mem[2] !== 8'h03 || s_mem[3] !== 8'h02 || s_mem[1] !== 8'h01 || s_mem[5] !== 8'h05) begin
      errors++;
      $display("[TB] FAIL %s_sram: got S1..3,5=%h %h %h %h, required 01 03 02 05", tag,
               s_mem[1], s_mem[2], s_mem[3], s_mem[5]);
    end
    checks++;
    if (m_key_bad !== 1'b0) begin errors++; $display("[TB] FAIL %s_key_bad: got %b, required 0", tag, m_key_bad); end
  endtask

  task automatic test_basic();
    int cyc;
    set_identity(8'h63, 8'h25);
    load_mems();
    run_sel(0, 100, -1, cyc);
    check_basic_result("basic", cyc);
    @(negedge clk);
    checks++;
    if (m_task_on !== 1'b0 || m_fin !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_return_idle: got task_on=%b fin=%b, required 0 0", m_task_on, m_fin);
    end
  endtask

  task automatic test_no_check();
    int cyc, wr0;
    set_identity(8'h00, 8'h25);
    load_mems();
    wr0 = pt_wr_count;
    run_sel(1, 100, -1, cyc);
    checks++;
    if (cyc !== 19) begin errors++; $display("[TB] FAIL nocheck_cycles: got %0d, required 19", cyc); end
    checks++;
    if (pt_mem[0] !== 8'h02 || pt_mem[1] !== 8'h20 || pt_wr_count - wr0 !== 2) begin
      errors++;
      $display("[TB] FAIL nocheck_pt: got %h %h writes=%0d, required 02 20 writes=2",
               pt_mem[0], pt_mem[1], pt_wr_count - wr0);
    end
    checks++;
    if (m_key_bad !== 1'b0) begin errors++; $display("[TB] FAIL nocheck_key_bad: got %b, required 0", m_key_bad); end
  endtask

  task automatic test_start_ignored();
    int cyc;
    set_identity(8'h63, 8'h25);
    load_mems();
    run_sel(0, 100, 7, cyc);
    check_basic_result("midstart", cyc);
  endtask

  task automatic test_reset_midrun();
    int cyc;
    set_identity(8'h63, 8'h25);
    load_mems();
    sel = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (m_task_on !== 1'b1) begin errors++; $display("[TB] FAIL midrun_busy: got task_on=%b, required 1", m_task_on); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m_out !== 45'd0) begin errors++; $display("[TB] FAIL midrun_reset_out: got %h, required 0", m_out); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m_out !== 45'd0) begin errors++; $display("[TB] FAIL midrun_idle_out: got %h, required 0", m_out); end
    load_mems();
    run_sel(0, 100, -1, cyc);
    check_basic_result("rerun", cyc);
  endtask

  task automatic test_long();
    logic [7:0] key [5];
    logic [7:0] ii, jj, t, tmp;
    logic [255:0] seen;
    int cyc, wr0, bad, first;
    for (int n = 0; n < 5; n++) key[n] = 8'($urandom);
    for (int a = 0; a < 256; a++) ms[a] = 8'(a);
    jj = 8'h00;
    for (int a = 0; a < 256; a++) begin
      jj = jj + ms[a] + key[a % 5];
      tmp = ms[a]; ms[a] = ms[jj]; ms[jj] = tmp;
    end
    for (int a = 0; a < 256; a++) s_init[a] = ms[a];
    ii = 8'h00; jj = 8'h00;
    for (int n = 0; n < 256; n++) begin
      ii = ii + 8'd1;
      jj = jj + ms[ii];
      tmp = ms[ii]; ms[ii] = ms[jj]; ms[jj] = tmp;
      t = ms[ii] + ms[jj];
      tmp = 8'($urandom_range(0, 26));
      pt_exp[n]  = (tmp == 8'd26) ? 8'h20 : 8'h61 + tmp;
      ct_init[n] = pt_exp[n] ^ ms[t];
    end
    load_mems();
    wr0 = pt_wr_count;
    run_sel(2, 3000, -1, cyc);
    checks++;
    if (cyc !== 2305) begin errors++; $display("[TB] FAIL long_cycles: got %0d, required 2305", cyc); end
    bad = 0; first = -1;
    for (int n = 0; n < 256; n++)
      if (pt_mem[n] !== pt_exp[n]) begin bad++; if (first < 0) first = n; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL long_pt: %0d bytes differ, first at %0d got %h required %h",
               bad, first, pt_mem[first], pt_exp[first]);
    end
    bad = 0; seen = '0;
    for (int a = 0; a < 256; a++) begin
      if (s_mem[a] !== ms[a]) bad++;
      seen[s_mem[a]] = 1'b1;
    end
    checks++;
    if (bad != 0 || seen !== {256{1'b1}}) begin
      errors++;
      $display("[TB] FAIL long_sram: got %0d words differing from model, permutation=%b, required 0 and 1",
               bad, &seen);
    end
    checks++;
    if (pt_wr_count - wr0 !== 256 || m_key_bad !== 1'b0 || m_ct_addr !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL long_final: got writes=%0d key_bad=%b k=%h, required 256 0 ff",
               pt_wr_count - wr0, m_key_bad, m_ct_addr);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pt_wr_count = 0;
    $display("[TB] rc4_prga bench starting");
    test_reset();
    test_invalid_abort();
    test_key_bad_hold();
    test_basic();
    test_no_check();
    test_start_ignored();
    test_reset_midrun();
    test_long();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
